// File: rtl/controlador_nivel.sv
// rtl/controlador_nivel.sv - fill/empty level sequencer for the 7-row LED level display
module controlador_nivel #(
  parameter int DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enche,
  input  logic       esvazia,
  input  logic       parar,
  output logic [6:0] linha_encher,
  output logic [6:0] linha_esvaziar,
  output logic       sel,
  output logic [2:0] nivel,
  output logic       cheio,
  output logic       vazio,
  output logic       ocupado
);

  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {
    REPOUSO    = 2'd0,
    ENCHENDO   = 2'd1,
    ESVAZIANDO = 2'd2
  } estado_t;

  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic          r_pisca;
  estado_t       r_estado;
  logic [2:0]    r_nivel;
  logic          r_sel;
  logic          r_ocupado;
  logic [7:0]    w_therm8;
  logic [6:0]    w_therm;

  assign w_tick = (r_cnt == CW'(DIV - 1));

  // Free-running prescaler; never realigned when a fill or empty starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Blink phase flips on every tick, in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pisca <= 1'b0;
    end else if (w_tick) begin
      r_pisca <= ~r_pisca;
    end
  end

  // Sequencer: level steps on ticks, stops at the limits or on abort; sel/ocupado follow the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= REPOUSO;
      r_nivel   <= 3'd0;
      r_sel     <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      case (r_estado)
        REPOUSO: begin
          if (enche && !esvazia && r_nivel != 3'd7) begin
            r_estado  <= ENCHENDO;
            r_sel     <= 1'b0;
            r_ocupado <= 1'b1;
          end else if (esvazia && !enche && r_nivel != 3'd0) begin
            r_estado  <= ESVAZIANDO;
            r_sel     <= 1'b1;
            r_ocupado <= 1'b1;
          end
        end
        ENCHENDO: begin
          if (parar) begin
            r_estado  <= REPOUSO;
            r_ocupado <= 1'b0;
          end else if (w_tick && r_nivel != 3'd7) begin
            r_nivel <= r_nivel + 3'd1;
            if (r_nivel == 3'd6) begin
              r_estado  <= REPOUSO;
              r_ocupado <= 1'b0;
            end
          end
        end
        ESVAZIANDO: begin
          if (parar) begin
            r_estado  <= REPOUSO;
            r_sel     <= 1'b0;
            r_ocupado <= 1'b0;
          end else if (w_tick && r_nivel != 3'd0) begin
            r_nivel <= r_nivel - 3'd1;
            if (r_nivel == 3'd1) begin
              r_estado  <= REPOUSO;
              r_sel     <= 1'b0;
              r_ocupado <= 1'b0;
            end
          end
        end
        default: begin
          r_estado  <= REPOUSO;
          r_sel     <= 1'b0;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  // Row patterns decoded from registers only: thermometer plus the blinking row.
  always_comb begin
    w_therm8       = (8'd1 << r_nivel) - 8'd1;
    w_therm        = w_therm8[6:0];
    linha_encher   = w_therm;
    linha_esvaziar = w_therm;
    if (r_estado == ENCHENDO && r_nivel != 3'd7) begin
      linha_encher[r_nivel] = r_pisca;
    end
    if (r_estado == ESVAZIANDO && r_nivel != 3'd0) begin
      linha_esvaziar[r_nivel - 3'd1] = r_pisca;
    end
  end

  assign sel     = r_sel;
  assign ocupado = r_ocupado;
  assign nivel   = r_nivel;
  assign cheio   = (r_nivel == 3'd7);
  assign vazio   = (r_nivel == 3'd0);

endmodule
